// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multi-cycle RISC-V core.
// Steps one state per clock through fetch, decode, execute, memory and
// writeback. It drives the datapath muxes, the write enables and the ALU
// decoder input. Fetch and memory states wait for mem_ready. The block also
// counts retired instructions.
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   op                opcode from the IR, stable from DECODE until FETCH
//   zero              ALU zero flag, used for beq
//   mem_ready         unified memory finished the current access this cycle
//   pc_write          PC enable = pc_update | (branch & zero)
//   adr_src           memory address select (0 PC, 1 Result)
//   mem_write         data memory write strobe
//   ir_write          IR/OldPC load
//   result_src        00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a         00 PC, 01 OldPC, 10 RD1
//   alu_src_b         00 WriteData, 01 ImmExt, 10 const 4
//   alu_op            00 add, 01 sub, 10 funct-decoded
//   reg_write         register file write
//   illegal_op        unsupported opcode seen in DECODE
//   instr_count       retired-instruction count, wraps
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC once memory is ready
// DECODE   | read registers, precompute branch target OldPC+imm
// MEMADR   | RD1+imm address for lw/sw
// MEMREAD  | load data from memory, wait for mem_ready
// MEMWB    | write loaded data to the register file
// MEMWRITE | store data, wait for mem_ready
// EXECUTER | R-type ALU operation
// EXECUTEI | I-type ALU operation
// ALUWB    | write the ALU result to the register file
// BEQ      | compare, take the precomputed target when zero
// JAL      | PC <- target, link value OldPC+4, then writeback
module multicycle_control_fsm #(
   parameter int STATE_W     = 4,
   parameter int INSTR_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [6:0]             op,
   input  logic                   zero,
   input  logic                   mem_ready,
   output logic                   pc_write,
   output logic                   adr_src,
   output logic                   mem_write,
   output logic                   ir_write,
   output logic [1:0]             result_src,
   output logic [1:0]             alu_src_a,
   output logic [1:0]             alu_src_b,
   output logic [1:0]             alu_op,
   output logic                   reg_write,
   output logic                   illegal_op,
   output logic [INSTR_CNT_W-1:0] instr_count
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [STATE_W-1:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
   } state_t;

   state_t state, state_next;
   logic   pc_update;
   logic   branch;
   logic   retire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         instr_count <= '0;
      end else begin
         state <= state_next;
         if (retire)
            instr_count <= instr_count + INSTR_CNT_W'(1);
      end
   end

   always_comb begin
      state_next = FETCH;
      pc_update  = 1'b0;
      branch     = 1'b0;
      retire     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      case (state)
         FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            // The IR and PC must not load until the instruction word is valid.
            ir_write   = mem_ready;
            pc_update  = mem_ready;
            state_next = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECUTER;
               OP_I:         state_next = EXECUTEI;
               OP_BEQ:       state_next = BEQ;
               OP_JAL:       state_next = JAL;
               default: begin
                  illegal_op = 1'b1;
                  state_next = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            adr_src    = 1'b1;
            state_next = mem_ready ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            retire     = 1'b1;
         end
         MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            retire     = mem_ready;
            state_next = mem_ready ? FETCH : MEMWRITE;
         end
         EXECUTER: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b10;
            state_next = ALUWB;
         end
         EXECUTEI: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            alu_op     = 2'b10;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
            retire    = 1'b1;
         end
         JAL: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            pc_update  = 1'b1;
            state_next = ALUWB;
         end
         default: state_next = FETCH;
      endcase
   end

   assign pc_write = pc_update | (branch & zero);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

   localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
   localparam int S_ER = 6, S_EI = 7, S_AWB = 8, S_BEQ = 9, S_JAL = 10;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   logic clk = 1'b0;
   logic reset, zero, mem_ready;
   logic [6:0] op;

   logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic [31:0] instr_count;

   logic d_pc_write, d_adr_src, d_mem_write, d_ir_write, d_reg_write, d_illegal_op;
   logic [1:0] d_result_src, d_alu_src_a, d_alu_src_b, d_alu_op;
   logic [3:0] cnt4;

   logic [13:0] obs;
   assign obs = {pc_write, adr_src, mem_write, ir_write, result_src,
                 alu_src_a, alu_src_b, alu_op, reg_write, illegal_op};

   int n_cmp = 0;
   int n_fail = 0;
   logic [31:0] exp_cnt = '0;

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
      .illegal_op(illegal_op), .instr_count(instr_count)
   );

   multicycle_control_fsm #(.INSTR_CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(d_pc_write), .adr_src(d_adr_src), .mem_write(d_mem_write),
      .ir_write(d_ir_write), .result_src(d_result_src), .alu_src_a(d_alu_src_a),
      .alu_src_b(d_alu_src_b), .alu_op(d_alu_op), .reg_write(d_reg_write),
      .illegal_op(d_illegal_op), .instr_count(cnt4)
   );

   // Expected output vector for a state, in the same bit order as obs.
   function automatic logic [13:0] exp_out(input int s, input logic mr,
                                           input logic z, input logic [6:0] o);
      logic pw, ad, mw, iw, rw, il;
      logic [1:0] rs, a, b, ao;
      pw = 0; ad = 0; mw = 0; iw = 0; rw = 0; il = 0;
      rs = 2'b00; a = 2'b00; b = 2'b00; ao = 2'b00;
      case (s)
         S_F:   begin b = 2'b10; rs = 2'b10; iw = mr; pw = mr; end
         S_D:   begin a = 2'b01; b = 2'b01;
                   il = !(o == OP_LW || o == OP_SW || o == OP_R || o == OP_I ||
                          o == OP_BEQ || o == OP_JAL); end
         S_MA:  begin a = 2'b10; b = 2'b01; end
         S_MR:  begin ad = 1; end
         S_MWB: begin rs = 2'b01; rw = 1; end
         S_MW:  begin ad = 1; mw = 1; end
         S_ER:  begin a = 2'b10; b = 2'b00; ao = 2'b10; end
         S_EI:  begin a = 2'b10; b = 2'b01; ao = 2'b10; end
         S_AWB: begin rw = 1; end
         S_BEQ: begin a = 2'b10; ao = 2'b01; pw = z; end
         S_JAL: begin a = 2'b01; b = 2'b10; pw = 1; end
         default: ;
      endcase
      return {pw, ad, mw, iw, rs, a, b, ao, rw, il};
   endfunction

   task automatic test_reset();
      int seq_r[4] = '{S_F, S_D, S_ER, S_AWB};
      int seq_l[4] = '{S_F, S_D, S_MA, S_MR};
      logic mr_l[4] = '{1, 1, 1, 0};
      int seq_i[3] = '{S_D, S_EI, S_AWB};
      logic [13:0] e;
      reset = 1; mem_ready = 0; zero = 0; op = OP_R;
      @(negedge clk);
      e = exp_out(S_F, 0, 0, op);
      n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, e); end
      n_cmp++; if (instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", instr_count); end
      @(posedge clk); #1;
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1;
         @(negedge clk);
         e = exp_out(seq_r[i], 1, zero, op);
         n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL reset_pre_rtype step %0d: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      exp_cnt = 1;
      op = OP_LW;
      for (int i = 0; i < 4; i++) begin
         mem_ready = mr_l[i];
         @(negedge clk);
         e = exp_out(seq_l[i], mr_l[i], zero, op);
         n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL reset_pre_lw step %0d: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      // Now sitting in MEMREAD with mem_ready low: assert reset mid-cycle.
      mem_ready = 0;
      #2 reset = 1;
      #1;
      exp_cnt = 0;
      e = exp_out(S_F, 0, 0, op);
      n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL reset_async_outputs: got %b want %b", obs, e); end
      n_cmp++; if (instr_count !== exp_cnt) begin n_fail++; $display("FAIL reset_async_count: got %0d want %0d", instr_count, exp_cnt); end
      mem_ready = 1;
      #1;
      n_cmp++; if ({ir_write, pc_write} !== 2'b11) begin n_fail++; $display("FAIL reset_fetch_ready: got %b want 11", {ir_write, pc_write}); end
      @(negedge clk);
      reset = 0;
      op = OP_I;
      #1;
      e = exp_out(S_F, 1, 0, op);
      n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL reset_release_first: got %b want %b", obs, e); end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = exp_out(seq_i[i], 1, zero, op);
         n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL reset_post_itype step %0d: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      exp_cnt = 1;
      n_cmp++; if (instr_count !== exp_cnt) begin n_fail++; $display("FAIL reset_post_count: got %0d want %0d", instr_count, exp_cnt); end
   endtask

   task automatic test_rtype();
      int seq[5] = '{S_F, S_F, S_D, S_ER, S_AWB};
      logic mr[5] = '{0, 1, 1, 1, 1};
      logic [13:0] e;
      op = OP_R; zero = 0;
      for (int i = 0; i < 5; i++) begin
         mem_ready = mr[i];
         @(negedge clk);
         e = exp_out(seq[i], mr[i], zero, op);
         n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL rtype step %0d: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      exp_cnt++;
      n_cmp++; if (instr_count !== exp_cnt) begin n_fail++; $display("FAIL rtype_count: got %0d want %0d", instr_count, exp_cnt); end
   endtask

   task automatic test_load();
      int seq[7] = '{S_F, S_D, S_MA, S_MR, S_MR, S_MR, S_MWB};
      logic mr[7] = '{1, 1, 1, 0, 0, 1, 1};
      logic [13:0] e;
      op = OP_LW; zero = 0;
      for (int i = 0; i < 7; i++) begin
         mem_ready = mr[i];
         @(negedge clk);
         e = exp_out(seq[i], mr[i], zero, op);
         n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL load step %0d: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      exp_cnt++;
      n_cmp++; if (instr_count !== exp_cnt) begin n_fail++; $display("FAIL load_count: got %0d want %0d", instr_count, exp_cnt); end
   endtask

   task automatic test_store();
      int seq[6] = '{S_F, S_D, S_MA, S_MW, S_MW, S_MW};
      logic mr[6] = '{1, 1, 1, 0, 0, 1};
      logic [13:0] e;
      op = OP_SW; zero = 0;
      for (int i = 0; i < 6; i++) begin
         mem_ready = mr[i];
         @(negedge clk);
         e = exp_out(seq[i], mr[i], zero, op);
         n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL store step %0d: got %b want %b", i, obs, e); end
         if (i == 3) begin
            n_cmp++; if (instr_count !== exp_cnt) begin n_fail++; $display("FAIL store_wait_count: got %0d want %0d", instr_count, exp_cnt); end
         end
         @(posedge clk); #1;
      end
      exp_cnt++;
      n_cmp++; if (instr_count !== exp_cnt) begin n_fail++; $display("FAIL store_count: got %0d want %0d", instr_count, exp_cnt); end
   endtask

   task automatic test_branch();
      int seq[3] = '{S_F, S_D, S_BEQ};
      logic zv[2] = '{1, 0};
      logic [13:0] e;
      op = OP_BEQ; mem_ready = 1;
      for (int k = 0; k < 2; k++) begin
         zero = zv[k];
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_out(seq[i], 1, zero, op);
            n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL branch z=%0b step %0d: got %b want %b", zero, i, obs, e); end
            @(posedge clk); #1;
         end
         exp_cnt++;
      end
      zero = 0;
      n_cmp++; if (instr_count !== exp_cnt) begin n_fail++; $display("FAIL branch_count: got %0d want %0d", instr_count, exp_cnt); end
   endtask

   task automatic test_jal();
      int seq[4] = '{S_F, S_D, S_JAL, S_AWB};
      logic [13:0] e;
      op = OP_JAL; mem_ready = 1; zero = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = exp_out(seq[i], 1, zero, op);
         n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL jal step %0d: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      exp_cnt++;
      n_cmp++; if (instr_count !== exp_cnt) begin n_fail++; $display("FAIL jal_count: got %0d want %0d", instr_count, exp_cnt); end
   endtask

   task automatic test_illegal();
      int seq[4] = '{S_F, S_D, S_F, S_F};
      logic mr[4] = '{1, 1, 0, 1};
      logic [13:0] e;
      op = OP_BAD; zero = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = mr[i];
         @(negedge clk);
         e = exp_out(seq[i], mr[i], zero, op);
         n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL illegal step %0d: got %b want %b", i, obs, e); end
         @(posedge clk); #1;
      end
      // Last step left FETCH with mem_ready high: now in DECODE, illegal again.
      @(negedge clk);
      n_cmp++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_again: got %b want 1", illegal_op); end
      @(posedge clk); #1;
      n_cmp++; if (instr_count !== exp_cnt) begin n_fail++; $display("FAIL illegal_count: got %0d want %0d", instr_count, exp_cnt); end
   endtask

   task automatic test_wrap();
      int n;
      logic [3:0] e4;
      op = OP_BEQ; mem_ready = 1; zero = 0;
      n = 15 - int'(exp_cnt[3:0]);
      for (int k = 0; k < n; k++) begin
         repeat (3) @(posedge clk);
         #1;
         exp_cnt++;
      end
      e4 = exp_cnt[3:0];
      n_cmp++; if (cnt4 !== e4 || e4 !== 4'hF) begin n_fail++; $display("FAIL wrap_preset: got %0d want 15", cnt4); end
      repeat (3) @(posedge clk);
      #1;
      exp_cnt++;
      e4 = exp_cnt[3:0];
      n_cmp++; if (cnt4 !== e4) begin n_fail++; $display("FAIL wrap_zero: got %0d want %0d", cnt4, e4); end
      n_cmp++; if (instr_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_main_count: got %0d want %0d", instr_count, exp_cnt); end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_load();
      test_store();
      test_branch();
      test_jal();
      test_illegal();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multi-cycle RISC-V core.
- Sequences fetch, decode, execute, memory and writeback one state per clock.
- Drives the shared ALU through `alu_op`, which feeds the existing ALU decoder, and drives the datapath muxes and write enables.
- Holds fetch and memory states until unified memory returns `mem_ready`, and counts retired instructions.

Parameters:
- `STATE_W`, 4, width of the state register (11 states used).
- `INSTR_CNT_W`, 32, width of the retired-instruction counter; wraps modulo 2^`INSTR_CNT_W`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op`  in  7  opcode from instruction register; stable from DECODE until FETCH.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `pc_write`  out  1  PC enable = `pc_update` | (`branch` & `zero`); combinational.
- `adr_src`  out  1  0 = PC, 1 = Result.
- `mem_write`  out  1  data memory write.
- `ir_write`  out  1  IR/OldPC load.
- `result_src`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a`  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- `alu_src_b`  out  2  00 = WriteData, 01 = ImmExt, 10 = const 4.
- `alu_op`  out  2  00 = add, 01 = sub (branch), 10 = funct-decoded.
- `reg_write`  out  1  register file write.
- `illegal_op`  out  1  unsupported opcode flagged in DECODE.
- `instr_count`  out  `INSTR_CNT_W`  retired-instruction count.

Behaviour:
- **Structure:** Moore FSM with a registered state. All outputs decode from state, except:
  - `pc_write`, which also depends on `zero`;
  - `illegal_op`, which depends on `op`;
  - the `mem_ready` qualifications listed below.
- **Defaults:** every output is 0 unless listed for a state.
- **Reset:** asynchronous; state goes to FETCH and `instr_count` goes to 0. Outputs immediately take FETCH values with `mem_ready`-gated signals low. Reset mid-instruction abandons the instruction without a retire count.

States, asserted outputs and transitions:
- **FETCH:** `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` and `pc_update` are asserted only when `mem_ready`=1.
  - `mem_ready`=1 goes to DECODE; otherwise stay in FETCH.
- **DECODE:** `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (precomputes branch target).
  - `op` 0000011 or 0100011 goes to MEMADR.
  - 0110011 goes to EXECUTER; 0010011 goes to EXECUTEI.
  - 1100011 goes to BEQ; 1101111 goes to JAL.
  - Any other `op`: `illegal_op`=1 for this cycle, go to FETCH, no count increment.
- **MEMADR:** `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - lw goes to MEMREAD; sw goes to MEMWRITE.
- **MEMREAD:** `adr_src`=1, `result_src`=00.
  - Hold until `mem_ready`=1, then go to MEMWB.
- **MEMWB:** `result_src`=01, `reg_write`=1; go to FETCH and retire.
- **MEMWRITE:** `adr_src`=1, `result_src`=00, `mem_write`=1, held every cycle while waiting.
  - When `mem_ready`=1, go to FETCH and retire.
- **EXECUTER:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10; go to ALUWB.
- **EXECUTEI:** `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10; go to ALUWB.
- **ALUWB:** `result_src`=00, `reg_write`=1; go to FETCH and retire.
- **BEQ:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`=1.
  - `pc_write` = `zero`; go to FETCH and retire.
- **JAL:** `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_update`=1; go to ALUWB.
- **Unused encodings** go to FETCH next cycle; all outputs 0.

Retire counter:
- Increments exactly once per instruction, on the clock edge leaving MEMWB, ALUWB, BEQ, or MEMWRITE with `mem_ready`=1.
- JAL retires via ALUWB.
- Wraps at all-ones to 0.

Cycle counts with `mem_ready` always 1:
- lw 5, sw 4, R-type/I-type 4, beq 3, jal 4.
- Each `mem_ready`=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.

Test Plan:
1. Reset mid-MEMREAD with `mem_ready`=0 → state FETCH, `instr_count`=0, `ir_write`=0, `pc_write`=0; release with `mem_ready`=1 → `ir_write`=`pc_write`=1 in first cycle.
2. `op`=0110011, `mem_ready`=1 → FETCH, DECODE, EXECUTER (`alu_op`=10, `alu_src_b`=00), ALUWB (`reg_write`=1), then FETCH; `instr_count` 0→1.
3. `op`=0000011, `mem_ready` low 2 cycles in MEMREAD → states FETCH, DECODE, MEMADR, MEMREAD×3, MEMWB (`result_src`=01); 7 cycles total; count +1.
4. `op`=1100011 with `zero`=1 then `zero`=0 → BEQ `pc_write`=1 then 0; `alu_op`=01 both times; 3 cycles each; count +2.
5. `op`=1101111 → JAL `pc_write`=1, `alu_src_a`=01, `alu_src_b`=10, then ALUWB `reg_write`=1; count +1.
6. `op`=1111111 → DECODE `illegal_op`=1 for one cycle, next state FETCH, count unchanged; `instr_count` preset near all-ones (`INSTR_CNT_W`=4, 15 retires) → 16th retire wraps count to 0.
